// File: rtl/layer_seq_ctrl.sv
// Tiled layer sequencer: per output-channel tile it streams IFM/weight words over req/ack,
// kicks the PE array, then the store unit. Define LAYER_SEQ_PERF_EN to add perf_cycles.
module layer_seq_ctrl #(
    parameter int BYTES_LOG2 = 2,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [3:0]       kernel_w,
    input  logic [15:0]      ifm_w,
    input  logic [15:0]      ifm_c,
    input  logic [15:0]      ofm_c,
    input  logic [7:0]       tile,
    output logic             ifm_rd_req,
    output logic [CNT_W-1:0] ifm_rd_addr,
    input  logic             ifm_rd_ack,
    output logic             wt_rd_req,
    output logic [CNT_W-1:0] wt_rd_addr,
    input  logic             wt_rd_ack,
    output logic             cal_start,
    input  logic             cal_done,
    output logic             store_start,
    input  logic             store_done,
    output logic             busy,
    output logic             done,
    output logic [15:0]      tile_idx,
    output logic [2:0]       state_o
`ifdef LAYER_SEQ_PERF_EN
    ,
    output logic [31:0]      perf_cycles
`endif
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CAL   = 3'd2,
        S_STORE = 3'd3,
        S_NEXT  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_DW  = 2'd0;
    localparam logic [1:0] MODE_MUL = 2'd3;

    // Read handshake: one word moves on every cycle where req and ack are both high; req is
    // registered and stays high until the word counter reaches its target; ack alone is ignored.
    state_t           state_q, state_d;
    logic [1:0]       mode_q, mode_d;
    logic [3:0]       kw_q, kw_d;
    logic [15:0]      iw_q, iw_d, ic_q, ic_d, rem_q, rem_d, tile_idx_q, tile_idx_d;
    logic [7:0]       tile_q, tile_d;
    logic             zero_q, zero_d;
    logic [CNT_W-1:0] ifm_cnt_q, ifm_cnt_d, wt_cnt_q, wt_cnt_d;
    logic [CNT_W-1:0] ifm_tgt_q, ifm_tgt_d, wt_tgt_q, wt_tgt_d;
    logic [CNT_W-1:0] wt_base_q, wt_base_d, ifm_addr_q, ifm_addr_d, wt_addr_q, wt_addr_d;
    logic             ifm_req_q, ifm_req_d, wt_req_q, wt_req_d;
    logic             cal_start_q, cal_start_d, store_start_q, store_start_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             enter_load, last_tile;
    logic [7:0]       ch_d;
    logic [63:0]      ifm_prod, wt_prod;

    function automatic logic [CNT_W-1:0] ceil_words(input logic [63:0] p);
        logic [64:0] s;
        s = {1'b0, p} + ((65'd1 << BYTES_LOG2) - 65'd1);
        return CNT_W'(s >> BYTES_LOG2);
    endfunction

    always_comb begin
        state_d       = state_q;
        mode_d        = mode_q;
        kw_d          = kw_q;
        iw_d          = iw_q;
        ic_d          = ic_q;
        rem_d         = rem_q;
        tile_d        = tile_q;
        zero_d        = zero_q;
        tile_idx_d    = tile_idx_q;
        ifm_cnt_d     = ifm_cnt_q;
        wt_cnt_d      = wt_cnt_q;
        wt_base_d     = wt_base_q;
        ifm_req_d     = ifm_req_q;
        wt_req_d      = wt_req_q;
        busy_d        = busy_q;
        cal_start_d   = 1'b0;
        store_start_d = 1'b0;
        done_d        = 1'b0;
        enter_load    = 1'b0;
        // rem_q holds the output channels not yet covered by earlier tiles
        last_tile     = zero_q || (rem_q <= {8'd0, tile_q});

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d     = mode;
                    kw_d       = kernel_w;
                    iw_d       = ifm_w;
                    ic_d       = ifm_c;
                    rem_d      = ofm_c;
                    tile_d     = tile;
                    zero_d     = (tile == 8'd0) || (ofm_c == 16'd0) || (ifm_w == 16'd0);
                    tile_idx_d = 16'd0;
                    wt_base_d  = '0;
                    busy_d     = 1'b1;
                    if (zero_d) begin
                        state_d = S_NEXT;
                    end else begin
                        state_d    = S_LOAD;
                        enter_load = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (ifm_req_q && ifm_rd_ack) begin
                    ifm_cnt_d = ifm_cnt_q + 1'b1;
                    ifm_req_d = (ifm_cnt_d < ifm_tgt_q);
                end
                if (wt_req_q && wt_rd_ack) begin
                    wt_cnt_d = wt_cnt_q + 1'b1;
                    wt_req_d = (wt_cnt_d < wt_tgt_q);
                end
                if (!ifm_req_d && !wt_req_d) begin
                    state_d     = S_CAL;
                    cal_start_d = 1'b1;
                end
            end
            S_CAL: begin
                if (cal_done) begin
                    state_d       = S_STORE;
                    store_start_d = 1'b1;
                end
            end
            S_STORE: begin
                if (store_done) state_d = S_NEXT;
            end
            S_NEXT: begin
                if (last_tile) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    // every tile before the last is full, so its target is the weight stride
                    tile_idx_d = tile_idx_q + 16'd1;
                    rem_d      = rem_q - {8'd0, tile_q};
                    wt_base_d  = wt_base_q + wt_tgt_q;
                    state_d    = S_LOAD;
                    enter_load = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        ch_d     = (rem_d < {8'd0, tile_d}) ? rem_d[7:0] : tile_d;
        ifm_prod = 64'(iw_d) * 64'(iw_d) * 64'(ic_d);
        wt_prod  = 64'(kw_d) * 64'(kw_d) * 64'(ch_d);
        if (mode_d != MODE_DW) wt_prod = wt_prod * 64'(ic_d);
        ifm_tgt_d = ceil_words(ifm_prod);
        wt_tgt_d  = ceil_words(wt_prod);

        if (enter_load) begin
            ifm_cnt_d = '0;
            wt_cnt_d  = '0;
            ifm_req_d = (mode_d == MODE_DW || mode_d == MODE_MUL) && (tile_idx_d == 16'd0)
                        && (ifm_tgt_d != '0);
            wt_req_d  = (mode_d != MODE_MUL) && (wt_tgt_d != '0);
        end
        ifm_addr_d = ifm_cnt_d;
        wt_addr_d  = wt_base_d + wt_cnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            mode_q        <= '0;
            kw_q          <= '0;
            iw_q          <= '0;
            ic_q          <= '0;
            rem_q         <= '0;
            tile_q        <= '0;
            zero_q        <= 1'b0;
            tile_idx_q    <= '0;
            ifm_cnt_q     <= '0;
            wt_cnt_q      <= '0;
            ifm_tgt_q     <= '0;
            wt_tgt_q      <= '0;
            wt_base_q     <= '0;
            ifm_addr_q    <= '0;
            wt_addr_q     <= '0;
            ifm_req_q     <= 1'b0;
            wt_req_q      <= 1'b0;
            cal_start_q   <= 1'b0;
            store_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            kw_q          <= kw_d;
            iw_q          <= iw_d;
            ic_q          <= ic_d;
            rem_q         <= rem_d;
            tile_q        <= tile_d;
            zero_q        <= zero_d;
            tile_idx_q    <= tile_idx_d;
            ifm_cnt_q     <= ifm_cnt_d;
            wt_cnt_q      <= wt_cnt_d;
            ifm_tgt_q     <= ifm_tgt_d;
            wt_tgt_q      <= wt_tgt_d;
            wt_base_q     <= wt_base_d;
            ifm_addr_q    <= ifm_addr_d;
            wt_addr_q     <= wt_addr_d;
            ifm_req_q     <= ifm_req_d;
            wt_req_q      <= wt_req_d;
            cal_start_q   <= cal_start_d;
            store_start_q <= store_start_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

`ifdef LAYER_SEQ_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == S_IDLE && start) perf_d = '0;
        else if (busy_q && perf_q != 32'hFFFF_FFFF) perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) perf_q <= '0;
        else        perf_q <= perf_d;
    end

    assign perf_cycles = perf_q;
`endif

    assign ifm_rd_req  = ifm_req_q;
    assign ifm_rd_addr = ifm_addr_q;
    assign wt_rd_req   = wt_req_q;
    assign wt_rd_addr  = wt_addr_q;
    assign cal_start   = cal_start_q;
    assign store_start = store_start_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign tile_idx    = tile_idx_q;
    assign state_o     = state_q;
endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Self-checking bench for layer_seq_ctrl: randomized acks/descriptors against a closed-form
// model of the expected address streams and tile sequence.
module tb_layer_seq_ctrl;
  localparam int CNT_W = 32;
  localparam longint WORD_BYTES = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [1:0]       mode;
  logic [3:0]       kernel_w;
  logic [15:0]      ifm_w, ifm_c, ofm_c;
  logic [7:0]       tile;
  logic             ifm_rd_req, wt_rd_req, ifm_rd_ack, wt_rd_ack;
  logic [CNT_W-1:0] ifm_rd_addr, wt_rd_addr;
  logic             cal_start, cal_done, store_start, store_done;
  logic             busy, done;
  logic [15:0]      tile_idx;
  logic [2:0]       state_o;
`ifdef LAYER_SEQ_PERF_EN
  logic [31:0]      perf_cycles;
`endif

  int checks = 0;
  int failures = 0;

  logic [31:0] exp_ifm_q[$], exp_wt_q[$], obs_ifm_q[$], obs_wt_q[$];
  logic [15:0] exp_tile_q[$], obs_tile_q[$];
  int n_cal, n_store, n_done, busy_cnt, first_cal_cyc;
  bit ifm_req_seen, wt_req_seen;

  // clock / reset
  always #5 clk = ~clk;

  layer_seq_ctrl #(.BYTES_LOG2(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .kernel_w(kernel_w),
    .ifm_w(ifm_w), .ifm_c(ifm_c), .ofm_c(ofm_c), .tile(tile),
    .ifm_rd_req(ifm_rd_req), .ifm_rd_addr(ifm_rd_addr), .ifm_rd_ack(ifm_rd_ack),
    .wt_rd_req(wt_rd_req), .wt_rd_addr(wt_rd_addr), .wt_rd_ack(wt_rd_ack),
    .cal_start(cal_start), .cal_done(cal_done),
    .store_start(store_start), .store_done(store_done),
    .busy(busy), .done(done), .tile_idx(tile_idx), .state_o(state_o)
`ifdef LAYER_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  // reference model
  function automatic longint cdiv(input longint a, input longint b);
    return (a + b - 1) / b;
  endfunction

  function automatic longint wt_words(input logic [1:0] m, input logic [3:0] kw,
                                      input logic [15:0] ic, input longint ch);
    longint p;
    p = longint'(kw) * longint'(kw) * ch;
    if (m != 2'd0) p = p * longint'(ic);
    return cdiv(p, WORD_BYTES);
  endfunction

  task automatic build_expected(input logic [1:0] m, input logic [3:0] kw, input logic [15:0] iw,
                                input logic [15:0] ic, input logic [15:0] oc, input logic [7:0] tl);
    longint nt, wfull, ch, n, nifm;
    exp_ifm_q.delete();
    exp_wt_q.delete();
    exp_tile_q.delete();
    nt = cdiv(longint'(oc), longint'(tl));
    wfull = wt_words(m, kw, ic, longint'(tl));
    for (longint t = 0; t < nt; t++) begin
      ch = (t == nt - 1) ? longint'(oc) - (nt - 1) * longint'(tl) : longint'(tl);
      n = wt_words(m, kw, ic, ch);
      if (m != 2'd3)
        for (longint i = 0; i < n; i++) exp_wt_q.push_back(32'(t * wfull + i));
      exp_tile_q.push_back(16'(t));
    end
    if (m == 2'd0 || m == 2'd3) begin
      nifm = cdiv(longint'(iw) * longint'(iw) * longint'(ic), WORD_BYTES);
      for (longint i = 0; i < nifm; i++) exp_ifm_q.push_back(32'(i));
    end
  endtask

  task automatic idle_inputs();
    start = 1'b0; ifm_rd_ack = 1'b0; wt_rd_ack = 1'b0;
    cal_done = 1'b0; store_done = 1'b0;
  endtask

  // driver + scoreboard for one non-zero descriptor
  task automatic run_layer(input logic [1:0] m, input logic [3:0] kw, input logic [15:0] iw,
                           input logic [15:0] ic, input logic [15:0] oc, input logic [7:0] tl,
                           input int ack_pct, input int cal_dly, input int st_dly);
    int cyc, cal_wait, st_wait, last_sd;
    bit got_done;
    build_expected(m, kw, iw, ic, oc, tl);
    obs_ifm_q.delete(); obs_wt_q.delete(); obs_tile_q.delete();
    n_cal = 0; n_store = 0; n_done = 0; busy_cnt = 0; first_cal_cyc = -1;
    ifm_req_seen = 0; wt_req_seen = 0;
    @(negedge clk);
    mode = m; kernel_w = kw; ifm_w = iw; ifm_c = ic; ofm_c = oc; tile = tl; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mode = 2'($urandom_range(3)); kernel_w = 4'($urandom_range(15));
    ifm_w = 16'($urandom); ifm_c = 16'($urandom); ofm_c = 16'($urandom); tile = 8'($urandom);
    checks++;
    if (state_o !== 3'd1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL start_to_load: state=%0d busy=%b, want state=1 busy=1", state_o, busy);
    end
    cyc = 1; got_done = 0; cal_wait = 0; st_wait = 0; last_sd = -100;
    while (!got_done && cyc < 5000) begin
      if (busy) busy_cnt++;
      if (ifm_rd_req) ifm_req_seen = 1;
      if (wt_rd_req) wt_req_seen = 1;
      ifm_rd_ack = ($urandom_range(99) < ack_pct);
      wt_rd_ack = ($urandom_range(99) < ack_pct);
      if (ifm_rd_req && ifm_rd_ack) obs_ifm_q.push_back(ifm_rd_addr);
      if (wt_rd_req && wt_rd_ack) obs_wt_q.push_back(wt_rd_addr);
      if (cal_start) begin
        n_cal++;
        obs_tile_q.push_back(tile_idx);
        if (n_cal == 1) first_cal_cyc = cyc;
        cal_wait = cal_dly + 1;
      end
      if (store_start) begin
        n_store++;
        st_wait = st_dly + 1;
      end
      cal_done = 1'b0;
      if (cal_wait > 0) begin
        cal_wait--;
        if (cal_wait == 0) cal_done = 1'b1;
      end else if (state_o == 3'd1) begin
        cal_done = ($urandom_range(3) == 0);
      end
      store_done = 1'b0;
      if (st_wait > 0) begin
        st_wait--;
        if (st_wait == 0) begin
          store_done = 1'b1;
          last_sd = cyc;
        end
      end else if (state_o == 3'd1 || state_o == 3'd2) begin
        store_done = ($urandom_range(3) == 0);
      end
      start = busy && ($urandom_range(7) == 0);
      if (done) begin
        n_done++;
        got_done = 1;
        checks++;
        if (cyc != last_sd + 2 || busy !== 1'b0) begin
          failures++;
          $display("FAIL done_timing: done at cycle %0d busy=%b, want cycle %0d busy=0",
                   cyc, busy, last_sd + 2);
        end
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    idle_inputs();
    checks++;
    if (!got_done) begin
      failures++;
      $display("FAIL layer_timeout: no done within %0d cycles", cyc);
    end
    checks++;
    if (obs_ifm_q.size() != exp_ifm_q.size()) begin
      failures++;
      $display("FAIL ifm_count: got %0d words, want %0d", obs_ifm_q.size(), exp_ifm_q.size());
    end
    for (int i = 0; i < exp_ifm_q.size() && i < obs_ifm_q.size(); i++) begin
      checks++;
      if (obs_ifm_q[i] !== exp_ifm_q[i]) begin
        failures++;
        $display("FAIL ifm_addr[%0d]: got %0d, want %0d", i, obs_ifm_q[i], exp_ifm_q[i]);
      end
    end
    checks++;
    if (obs_wt_q.size() != exp_wt_q.size()) begin
      failures++;
      $display("FAIL wt_count: got %0d words, want %0d", obs_wt_q.size(), exp_wt_q.size());
    end
    for (int i = 0; i < exp_wt_q.size() && i < obs_wt_q.size(); i++) begin
      checks++;
      if (obs_wt_q[i] !== exp_wt_q[i]) begin
        failures++;
        $display("FAIL wt_addr[%0d]: got %0d, want %0d", i, obs_wt_q[i], exp_wt_q[i]);
      end
    end
    checks++;
    if (ifm_req_seen != (exp_ifm_q.size() > 0) || wt_req_seen != (exp_wt_q.size() > 0)) begin
      failures++;
      $display("FAIL req_presence: ifm=%0d wt=%0d, want ifm=%0d wt=%0d", ifm_req_seen,
               wt_req_seen, exp_ifm_q.size() > 0, exp_wt_q.size() > 0);
    end
    checks++;
    if (obs_tile_q != exp_tile_q) begin
      failures++;
      $display("FAIL tile_seq: got %p, want %p", obs_tile_q, exp_tile_q);
    end
    checks++;
    if (n_cal != exp_tile_q.size() || n_store != exp_tile_q.size() || n_done != 1) begin
      failures++;
      $display("FAIL kick_counts: cal=%0d store=%0d done=%0d, want %0d/%0d/1",
               n_cal, n_store, n_done, exp_tile_q.size(), exp_tile_q.size());
    end
`ifdef LAYER_SEQ_PERF_EN
    checks++;
    if (perf_cycles !== 32'(busy_cnt)) begin
      failures++;
      $display("FAIL perf_at_done: got %0d, want %0d", perf_cycles, busy_cnt);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (perf_cycles !== 32'(busy_cnt)) begin
      failures++;
      $display("FAIL perf_hold: got %0d, want %0d", perf_cycles, busy_cnt);
    end
`endif
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (state_o !== 3'd0 || tile_idx !== 16'd0) begin
      failures++;
      $display("FAIL reset_state: state=%0d tile_idx=%0d, want 0/0", state_o, tile_idx);
    end
    checks++;
    if ({busy, done, cal_start, store_start, ifm_rd_req, wt_rd_req} !== 6'b0 ||
        ifm_rd_addr !== '0 || wt_rd_addr !== '0) begin
      failures++;
      $display("FAIL reset_outputs: flags=%b ifm_addr=%0d wt_addr=%0d, want all 0",
               {busy, done, cal_start, store_start, ifm_rd_req, wt_rd_req},
               ifm_rd_addr, wt_rd_addr);
    end
  endtask

  task automatic test_dw();
    run_layer(2'd0, 4'd3, 16'd4, 16'd8, 16'd8, 8'd8, 100, 0, 0);
    checks++;
    if (obs_ifm_q.size() != 32 || obs_wt_q.size() != 18) begin
      failures++;
      $display("FAIL dw_word_counts: ifm=%0d wt=%0d, want 32/18", obs_ifm_q.size(),
               obs_wt_q.size());
    end
    checks++;
    if (first_cal_cyc != 33) begin
      failures++;
      $display("FAIL dw_throughput: cal_start at cycle %0d, want 33", first_cal_cyc);
    end
  endtask

  task automatic test_expand();
    run_layer(2'd2, 4'd1, 16'd5, 16'd8, 16'd10, 8'd4, 100, 1, 2);
    checks++;
    if (obs_wt_q.size() != 20 || obs_wt_q[8] !== 32'd8 || obs_wt_q[16] !== 32'd16) begin
      failures++;
      $display("FAIL expand_bursts: count=%0d addr8=%0d addr16=%0d, want 20/8/16",
               obs_wt_q.size(), obs_wt_q[8], obs_wt_q[16]);
    end
  endtask

  task automatic test_mul_random();
    run_layer(2'd3, 4'd2, 16'd6, 16'd5, 16'd7, 8'd3, 50, 2, 1);
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++)
      run_layer(2'($urandom_range(3)), 4'($urandom_range(3, 1)), 16'($urandom_range(6, 1)),
                16'($urandom_range(6, 1)), 16'($urandom_range(10, 1)),
                8'($urandom_range(4, 1)), int'($urandom_range(100, 30)),
                int'($urandom_range(4)), int'($urandom_range(4)));
  endtask

  task automatic test_zero_work();
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      mode = 2'd0; kernel_w = 4'd3; ifm_w = 16'd4; ifm_c = 16'd8; ofm_c = 16'd8; tile = 8'd4;
      if (v == 0) tile = 8'd0;
      if (v == 1) ofm_c = 16'd0;
      if (v == 2) ifm_w = 16'd0;
      start = 1'b1;
      @(negedge clk);
      checks++;
      if (state_o !== 3'd4 || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL zero_next[%0d]: state=%0d busy=%b done=%b, want 4/1/0", v, state_o,
                 busy, done);
      end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (done !== 1'b1 || busy !== 1'b0 || state_o !== 3'd0) begin
        failures++;
        $display("FAIL zero_done[%0d]: done=%b busy=%b state=%0d, want 1/0/0", v, done, busy,
                 state_o);
      end
      @(negedge clk);
      checks++;
      if (state_o !== 3'd0 || done !== 1'b0 ||
          {ifm_rd_req, wt_rd_req, cal_start, store_start} !== 4'b0) begin
        failures++;
        $display("FAIL zero_quiet[%0d]: state=%0d done=%b reqs/kicks=%b, want 0/0/0000", v,
                 state_o, done, {ifm_rd_req, wt_rd_req, cal_start, store_start});
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    mode = 2'd0; kernel_w = 4'd3; ifm_w = 16'd4; ifm_c = 16'd8; ofm_c = 16'd8; tile = 8'd8;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0; ifm_rd_ack = 1'b1; wt_rd_ack = 1'b1;
    n = 0;
    while (state_o !== 3'd2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ifm_rd_ack = 1'b0; wt_rd_ack = 1'b0;
    checks++;
    if (state_o !== 3'd2) begin
      failures++;
      $display("FAIL reach_cal: state=%0d after %0d cycles, want 2", state_o, n);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (state_o !== 3'd0 || tile_idx !== 16'd0 ||
        {busy, done, cal_start, store_start, ifm_rd_req, wt_rd_req} !== 6'b0 ||
        ifm_rd_addr !== '0 || wt_rd_addr !== '0) begin
      failures++;
      $display("FAIL async_reset: state=%0d flags=%b ifm_addr=%0d wt_addr=%0d, want all 0",
               state_o, {busy, done, cal_start, store_start, ifm_rd_req, wt_rd_req},
               ifm_rd_addr, wt_rd_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_layer(2'd1, 4'd1, 16'd3, 16'd6, 16'd5, 8'd2, 70, 1, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    mode = 2'd0; kernel_w = 4'd0; ifm_w = 16'd0; ifm_c = 16'd0; ofm_c = 16'd0; tile = 8'd0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_dw();
    test_expand();
    test_mul_random();
    test_random();
    test_zero_work();
    test_reset_mid();
`ifdef LAYER_SEQ_PERF_EN
    run_layer(2'd0, 4'd3, 16'd4, 16'd8, 16'd8, 8'd8, 100, 10, 0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
